// File: rtl/aes_gf_pkg.sv
// rtl/aes_gf_pkg.sv - GF(2^8) helpers and FSM encoding shared by the AES inverse-mix datapath
package aes_gf_pkg;

    localparam logic [7:0] GF_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } imc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul09(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul0b(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul0d(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x;
    endfunction

    function automatic logic [7:0] gf_mul0e(input logic [7:0] x);
        logic [7:0] x2, x4, x8;
        x2 = xtime(x);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_columns_iter_if.sv
// rtl/inv_mix_columns_iter_if.sv - input and output state handshakes of the inverse-mix unit
interface inv_mix_columns_iter_if;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/inv_mix_single_column.sv
// rtl/inv_mix_single_column.sv - combinational InvMixColumns of one 32-bit column (s0 in MSB byte)
module inv_mix_single_column
    import aes_gf_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] mixed
);

    logic [7:0] s0, s1, s2, s3;
    logic [7:0] r0, r1, r2, r3;

    assign {s0, s1, s2, s3} = col;

    assign r0 = gf_mul0e(s0) ^ gf_mul0b(s1) ^ gf_mul0d(s2) ^ gf_mul09(s3);
    assign r1 = gf_mul09(s0) ^ gf_mul0e(s1) ^ gf_mul0b(s2) ^ gf_mul0d(s3);
    assign r2 = gf_mul0d(s0) ^ gf_mul09(s1) ^ gf_mul0e(s2) ^ gf_mul0b(s3);
    assign r3 = gf_mul0b(s0) ^ gf_mul0d(s1) ^ gf_mul09(s2) ^ gf_mul0e(s3);

    assign mixed = {r0, r1, r2, r3};

endmodule

// File: rtl/inv_mix_columns_iter.sv
// rtl/inv_mix_columns_iter.sv - iterative AES InvMixColumns, COLS_PER_CYCLE columns per busy cycle
module inv_mix_columns_iter
    import aes_gf_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    inv_mix_columns_iter_if.slave bus
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // col_idx wraps modulo 4, so with four columns per cycle the step is 0
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    imc_state_e   state, state_nxt;
    logic [1:0]   col_idx, col_idx_nxt;
    logic [127:0] work, work_nxt;
    logic         in_ready_c, out_valid_c;

    logic [31:0]  col_in  [COLS_PER_CYCLE];
    logic [31:0]  col_out [COLS_PER_CYCLE];

    always_comb begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            col_in[g] = work[{2'd3 - (col_idx + 2'(g)), 5'd0} +: 32];
        end
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        inv_mix_single_column u_col (
            .col   (col_in[g]),
            .mixed (col_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            col_idx <= 2'd0;
            work    <= '0;
        end else begin
            state   <= state_nxt;
            col_idx <= col_idx_nxt;
            work    <= work_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        col_idx_nxt = col_idx;
        work_nxt    = work;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_nxt   = BUSY;
                    col_idx_nxt = 2'd0;
                    work_nxt    = bus.in_data;
                end
            end
            BUSY: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    work_nxt[{2'd3 - (col_idx + 2'(g)), 5'd0} +: 32] = col_out[g];
                end
                col_idx_nxt = col_idx + STEP;
                if (col_idx == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = work;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// tb/tb_inv_mix_columns_iter.sv - directed and round-trip bench for inv_mix_columns_iter (1, 2 and 4 columns per cycle)
module tb_inv_mix_columns_iter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    inv_mix_columns_iter_if if1();
    inv_mix_columns_iter_if if2();
    inv_mix_columns_iter_if if4();

    inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Forward (encryption) MixColumns used to build round-trip stimulus
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3;
        {s0, s1, s2, s3} = c;
        return {xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3,
                s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3,
                s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3,
                xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3)};
    endfunction

    function automatic logic [127:0] mix_state(input logic [127:0] s);
        return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one vector into all three instances at once and checks latency and result of each
    task automatic run_vec(input string name, input logic [127:0] din, input logic [127:0] exp);
        int cyc;
        int lat1, lat2, lat4;
        logic [127:0] d1, d2, d4;
        cyc = 0;
        while (!(if1.in_ready && if2.in_ready && if4.in_ready) && cyc < 50) begin
            tick();
            cyc++;
        end
        check({name, "_ready"}, 128'(if1.in_ready && if2.in_ready && if4.in_ready), 128'd1);
        if1.out_ready = 1'b1; if2.out_ready = 1'b1; if4.out_ready = 1'b1;
        if1.in_data = din;    if2.in_data = din;    if4.in_data = din;
        if1.in_valid = 1'b1;  if2.in_valid = 1'b1;  if4.in_valid = 1'b1;
        lat1 = -1; lat2 = -1; lat4 = -1;
        d1 = '0; d2 = '0; d4 = '0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) begin
                if1.in_valid = 1'b0; if2.in_valid = 1'b0; if4.in_valid = 1'b0;
            end
            if (if1.out_valid && lat1 < 0) begin lat1 = c; d1 = if1.out_data; end
            if (if2.out_valid && lat2 < 0) begin lat2 = c; d2 = if2.out_data; end
            if (if4.out_valid && lat4 < 0) begin lat4 = c; d4 = if4.out_data; end
        end
        check({name, "_lat_c1"}, 128'(lat1), 128'd5);
        check({name, "_lat_c2"}, 128'(lat2), 128'd3);
        check({name, "_lat_c4"}, 128'(lat4), 128'd2);
        check({name, "_data_c1"}, d1, exp);
        check({name, "_data_c2"}, d2, exp);
        check({name, "_data_c4"}, d4, exp);
    endtask

    localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V1_EXP = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] V2_EXP = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] V3_IN  = 128'h01000000_80000000_01010101_00000000;
    localparam logic [127:0] V3_EXP = 128'h0e090d0b_41ecdaf7_01010101_00000000;

    initial begin
        int cyc;
        int pulses;
        int acc, got, last_acc;
        logic rdy;
        logic [127:0] cur_orig;
        logic [127:0] orig_q[$];

        checks = 0;
        failures = 0;
        rst = 1'b1;
        if1.in_valid = 1'b0; if1.in_data = '0; if1.out_ready = 1'b0;
        if2.in_valid = 1'b0; if2.in_data = '0; if2.out_ready = 1'b0;
        if4.in_valid = 1'b0; if4.in_data = '0; if4.out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        check("rst_in_ready", 128'(if1.in_ready), 128'd1);
        check("rst_out_valid", 128'(if1.out_valid), 128'd0);
        check("rst_out_data", if1.out_data, 128'd0);
        check("rst_out_data_c4", if4.out_data, 128'd0);

        run_vec("v1", V1_IN, V1_EXP);
        run_vec("v2", V2_IN, V2_EXP);
        run_vec("v3", V3_IN, V3_EXP);

        // Backpressure: hold DONE for 10 cycles while poking the input side
        if1.out_ready = 1'b0;
        if1.in_data = V1_IN;
        if1.in_valid = 1'b1;
        tick();
        if1.in_valid = 1'b0;
        cyc = 0;
        while (!if1.out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("bp_done_reached", 128'(if1.out_valid), 128'd1);
        for (int i = 0; i < 10; i++) begin
            if1.in_valid = i[0];
            if1.in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            check("bp_out_valid", 128'(if1.out_valid), 128'd1);
            check("bp_out_data", if1.out_data, V1_EXP);
            check("bp_in_ready", 128'(if1.in_ready), 128'd0);
        end
        if1.in_valid = 1'b0;
        if1.out_ready = 1'b1;
        tick();
        check("bp_release_valid", 128'(if1.out_valid), 128'd0);
        check("bp_release_ready", 128'(if1.in_ready), 128'd1);

        // Reset in BUSY cycle 2
        if1.in_data = V2_IN;
        if1.in_valid = 1'b1;
        tick();
        if1.in_valid = 1'b0;
        tick();
        check("mid_busy_in_ready", 128'(if1.in_ready), 128'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", 128'(if1.in_ready), 128'd1);
        check("mid_rst_out_valid", 128'(if1.out_valid), 128'd0);
        check("mid_rst_out_data", if1.out_data, 128'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (if1.out_valid) pulses++;
        end
        check("mid_rst_no_pulse", 128'(pulses), 128'd0);
        run_vec("post_rst", V1_IN, V1_EXP);

        // Round trip with in_valid held high back-to-back on the one-column instance
        if1.out_ready = 1'b1;
        acc = 0; got = 0; last_acc = -1; cyc = 0;
        cur_orig = {$urandom(), $urandom(), $urandom(), $urandom()};
        if1.in_data = mix_state(cur_orig);
        if1.in_valid = 1'b1;
        while (got < 1000 && cyc < 8000) begin
            rdy = if1.in_ready && if1.in_valid;
            tick();
            cyc++;
            if (rdy) begin
                orig_q.push_back(cur_orig);
                if (last_acc >= 0) check("rt_spacing", 128'(cyc - last_acc), 128'd6);
                last_acc = cyc;
                acc++;
                if (acc < 1000) begin
                    cur_orig = {$urandom(), $urandom(), $urandom(), $urandom()};
                    if1.in_data = mix_state(cur_orig);
                end else begin
                    if1.in_valid = 1'b0;
                end
            end
            if (if1.out_valid) begin
                if (orig_q.size() > 0) check("rt_data", if1.out_data, orig_q.pop_front());
                else check("rt_spurious_valid", 128'd1, 128'd0);
                got++;
            end
        end
        if1.in_valid = 1'b0;
        check("rt_count", 128'(got), 128'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
